usart_fifo: RTL and testbench

//   Byte FIFO buffering data between a USART receiver/transmitter and its host-side logic.

---
 rtl/usart_fifo_pkg.sv | 14 +
 rtl/usart_fifo_mem.sv | 30 +++
 rtl/usart_fifo.sv | 70 +++++++
 tb/tb_usart_fifo.sv | 127 ++++++++++++
 4 files changed

// File: rtl/usart_fifo_pkg.sv
// Constants shared by the USART RX/TX FIFO wrappers so that both paths agree
// on word width and buffer depth.
package usart_fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_ADDR_WIDTH = 4;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  localparam int FIFO_DEPTH = fifo_depth(FIFO_ADDR_WIDTH);

endpackage

// File: rtl/usart_fifo_mem.sv
// DEPTH x DATA_WIDTH storage with a synchronous write port and an asynchronous
// read port, so the FIFO head is visible in the same cycle the pointer moves.
module usart_fifo_mem
  import usart_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  comm_clock,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately never cleared; emptiness is tracked by the count.
  always_ff @(posedge comm_clock) begin
    if (write_en) begin
      mem[write_addr] <= write_data;
    end
  end

  assign read_data = mem[read_addr];

endmodule

// File: rtl/usart_fifo.sv
// First-word-fall-through byte FIFO between a USART and its host logic,
// with valid/ready handshakes on both sides.
module usart_fifo
  import usart_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  comm_clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  in_full,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic                  out_empty,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] write_ptr_reg;
  logic [ADDR_WIDTH-1:0] read_ptr_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic                  push;
  logic                  pop;

  assign out_empty = (count_reg == '0);
  assign in_full   = (count_reg == (ADDR_WIDTH+1)'(DEPTH));
  assign in_ready  = !in_full;
  assign out_valid = !out_empty;

  assign push = in_valid & in_ready;
  assign pop  = out_ready & out_valid;

  // The write is suppressed during reset so reset cleanly wins over a push.
  usart_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .comm_clock(comm_clock),
    .write_en  (push & !reset),
    .write_addr(write_ptr_reg),
    .write_data(in_data),
    .read_addr (read_ptr_reg),
    .read_data (out_data)
  );

  always_ff @(posedge comm_clock) begin
    if (reset) begin
      write_ptr_reg <= '0;
      read_ptr_reg  <= '0;
      count_reg     <= '0;
    end else begin
      if (push) begin
        write_ptr_reg <= write_ptr_reg + ADDR_WIDTH'(1);
      end
      if (pop) begin
        read_ptr_reg <= read_ptr_reg + ADDR_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (ADDR_WIDTH+1)'(1);
        2'b01:   count_reg <= count_reg - (ADDR_WIDTH+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_usart_fifo.sv
// Scoreboard bench for usart_fifo: words are queued as they are accepted and
// compared against the head of the FIFO as the reader consumes them.
module tb_usart_fifo;

  localparam int DEPTH = 16;

  logic       comm_clock = 1'b0;
  logic       reset      = 1'b1;
  logic       in_valid   = 1'b0;
  logic       in_ready;
  logic       in_full;
  logic [7:0] in_data    = 8'h00;
  logic       out_ready  = 1'b0;
  logic       out_valid;
  logic       out_empty;
  logic [7:0] out_data;

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] sb_q[$];

  always #5 comm_clock = ~comm_clock;

  usart_fifo dut (
    .comm_clock(comm_clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_full   (in_full),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_empty (out_empty),
    .out_data  (out_data)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive on the falling edge, check, then update the model at the rising edge.
  task automatic cycle(input logic iv, input logic [7:0] d, input logic ordy);
    bit do_push;
    bit do_pop;
    logic [7:0] popped;
    @(negedge comm_clock);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    check_val("out_empty", out_empty, sb_q.size() == 0);
    check_val("out_valid", out_valid, sb_q.size() != 0);
    check_val("in_full",   in_full,   sb_q.size() == DEPTH);
    check_val("in_ready",  in_ready,  sb_q.size() != DEPTH);
    do_pop  = ordy && (sb_q.size() > 0);
    do_push = iv && (sb_q.size() < DEPTH);
    if (sb_q.size() > 0) begin
      check_val(do_pop ? "pop_data" : "head_data", out_data, sb_q[0]);
    end
    @(posedge comm_clock);
    if (do_pop) begin
      popped = sb_q.pop_front();
      $display("pop  %02h", popped);
    end
    if (do_push) begin
      sb_q.push_back(d);
      $display("push %02h", d);
    end
  endtask

  // Reset with arbitrary handshake activity applied: reset must win and empty the model.
  task automatic do_reset(input int n, input logic iv, input logic [7:0] d, input logic ordy);
    @(negedge comm_clock);
    reset     = 1'b1;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    repeat (n) @(posedge comm_clock);
    @(negedge comm_clock);
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sb_q.delete();
    $display("reset (%0d cycles)", n);
  endtask

  initial begin
    do_reset(2, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);

    cycle(1'b1, 8'hAA, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'hBB, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b0);
    end

    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
    cycle(1'b1, 8'hFF, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h40 + i), 1'b1);
    check_val("wrap_count", sb_q.size(), 3);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
    do_reset(1, 1'b1, 8'h77, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h5A, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
